// File: rtl/video_timing_ctrl.sv
// Dot/line timing, PPU mode, LY/LYC compare and STAT/VBL interrupts with the ff41/ff44/ff45 CPU registers.
// Counters and mode update on the clk edge, register reads drive d in the same cycle, and there is no backpressure.
module video_timing_ctrl #(
    parameter int DOTS_PER_LINE   = 456,
    parameter int LINES           = 154,
    parameter int VBL_LINE        = 144,
    parameter int OAM_DOTS        = 80,
    parameter int HW              = 9,
    parameter int VW              = 8,
    parameter int LAST_LINE_QUIRK = 1
) (
    input  logic          clk,
    input  logic          reset_video,
    input  logic          lcd_en,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic          ff41,
    input  logic          ff44,
    input  logic          ff45,
    inout  wire  [7:0]    d,
    input  logic          render_done,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic [1:0]    mode,
    output logic          line_start,
    output logic          int_vbl,
    output logic          int_stat
);

    localparam logic [HW-1:0] H_LAST  = HW'(DOTS_PER_LINE - 1);
    localparam logic [HW-1:0] H_OAM   = HW'(OAM_DOTS);
    localparam logic [HW-1:0] H_QUIRK = HW'(4);
    localparam logic [VW-1:0] V_LAST  = VW'(LINES - 1);
    localparam logic [VW-1:0] V_VBL   = VW'(VBL_LINE);

    localparam logic [1:0] MODE_HBL  = 2'd0;
    localparam logic [1:0] MODE_VBL  = 2'd1;
    localparam logic [1:0] MODE_OAM  = 2'd2;
    localparam logic [1:0] MODE_XFER = 2'd3;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    mode_q, mode_d;
    logic          on_q;
    logic [7:0]    lyc_q;
    logic [3:0]    en_q;      // STAT bits 6:3
    logic          coin_q;
    logic          stat_q;
    logic          vbl_q;
    logic [7:0]    ly;
    logic          stat_line;
    logic [7:0]    rd_dat;
    logic          rd_en;

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        mode_d = mode_q;
        if (!lcd_en) begin
            h_d    = '0;
            v_d    = '0;
            mode_d = MODE_HBL;
        end else begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            // Mode follows the counter values it will be registered alongside.
            if (v_d >= V_VBL) begin
                mode_d = MODE_VBL;
            end else if (h_d < H_OAM) begin
                mode_d = MODE_OAM;
            end else if (h_d == H_OAM) begin
                mode_d = MODE_XFER;
            end else if (mode_q == MODE_XFER && (render_done || h_d == H_LAST)) begin
                mode_d = MODE_HBL;
            end
        end
    end

    assign ly = (LAST_LINE_QUIRK != 0 && v_q == V_LAST && h_q >= H_QUIRK) ? 8'd0 : 8'(v_q);

    // The vblank entry dot also fires the OAM source, matching the original hardware.
    assign stat_line = on_q && ((en_q[3] && coin_q) ||
                                (en_q[2] && (mode_q == MODE_OAM || (v_q == V_VBL && h_q == '0))) ||
                                (en_q[1] && mode_q == MODE_VBL) ||
                                (en_q[0] && mode_q == MODE_HBL));

    always_ff @(posedge clk) begin
        if (reset_video) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= MODE_HBL;
            on_q   <= 1'b0;
            lyc_q  <= 8'd0;
            en_q   <= 4'd0;
            coin_q <= 1'b0;
            stat_q <= 1'b0;
            vbl_q  <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            mode_q <= mode_d;
            on_q   <= lcd_en;
            coin_q <= (ly == lyc_q);
            stat_q <= lcd_en ? stat_line : 1'b0;
            vbl_q  <= lcd_en && h_d == '0 && v_d == V_VBL;
            if (cpu_wr && ff41) en_q  <= d[6:3];
            if (cpu_wr && ff45) lyc_q <= d;
        end
    end

    always_comb begin
        rd_dat = lyc_q;
        if (ff41) begin
            rd_dat = {1'b1, en_q, coin_q, lcd_en ? mode_q : 2'b00};
        end else if (ff44) begin
            rd_dat = ly;
        end
    end

    assign rd_en = cpu_rd && (ff41 || ff44 || ff45);
    assign d     = rd_en ? rd_dat : 8'hzz;

    assign h          = h_q;
    assign v          = v_q;
    assign mode       = mode_q;
    assign line_start = on_q && (h_q == '0);
    assign int_vbl    = vbl_q;
    assign int_stat   = stat_line && !stat_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a reduced 100-dot x 20-line geometry.
`timescale 1ns/1ps
module tb_video_timing_ctrl;

    localparam int DOTS = 100;
    localparam int LNS  = 20;
    localparam int VBL  = 16;
    localparam int OAM  = 20;

    logic       clk = 1'b0;
    logic       reset_video, lcd_en, cpu_rd, cpu_wr, ff41, ff44, ff45, render_done;
    logic       tb_oe;
    logic [7:0] tb_dat;
    wire  [7:0] d;
    logic [6:0] h;
    logic [4:0] v;
    logic [1:0] mode;
    logic       line_start, int_vbl, int_stat;

    int tests = 0;
    int fails = 0;

    assign d = tb_oe ? tb_dat : 8'hzz;

    always #5 clk = ~clk;

    video_timing_ctrl #(
        .DOTS_PER_LINE(DOTS), .LINES(LNS), .VBL_LINE(VBL), .OAM_DOTS(OAM),
        .HW(7), .VW(5), .LAST_LINE_QUIRK(1)
    ) dut (
        .clk(clk), .reset_video(reset_video), .lcd_en(lcd_en),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .ff41(ff41), .ff44(ff44), .ff45(ff45),
        .d(d), .render_done(render_done),
        .h(h), .v(v), .mode(mode), .line_start(line_start),
        .int_vbl(int_vbl), .int_stat(int_stat)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [2:0] sel;   // {ff45, ff44, ff41}
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        ff41 = 1'b0; ff44 = 1'b0; ff45 = 1'b0;
        tb_oe = 1'b0; tb_dat = 8'h00; render_done = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        lcd_en = 1'b0;
        reset_video = 1'b1;
        step();
        step();
        reset_video = 1'b0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] dat);
        {ff45, ff44, ff41} = sel;
        cpu_wr = 1'b1; tb_oe = 1'b1; tb_dat = dat;
        step();
        cpu_wr = 1'b0; tb_oe = 1'b0;
        {ff45, ff44, ff41} = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int eh, ev, ln, em, pc, ph, pv, c4, c5, c16, c19, c17;
        reset_video = 1'b1;
        lcd_en = 1'b0;
        bus_idle();

        tbl[0]  = '{1'b1, 1'b0, 3'b001, 8'h00, 8'h84};
        tbl[1]  = '{1'b0, 1'b1, 3'b100, 8'h07, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 8'h00, 8'h07};
        tbl[3]  = '{1'b1, 1'b0, 3'b001, 8'h00, 8'h80};
        tbl[4]  = '{1'b0, 1'b1, 3'b001, 8'hFF, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 3'b001, 8'h00, 8'hF8};
        tbl[6]  = '{1'b0, 1'b1, 3'b010, 8'h55, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 3'b010, 8'h00, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 3'b100, 8'h00, 8'h07};
        tbl[9]  = '{1'b0, 1'b1, 3'b001, 8'h28, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 3'b001, 8'h00, 8'hA8};
        tbl[11] = '{1'b0, 1'b1, 3'b100, 8'h03, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 3'b001, 8'h00, 8'hA8};
        tbl[13] = '{1'b1, 1'b0, 3'b100, 8'h00, 8'h03};
        tbl[14] = '{1'b1, 1'b0, 3'b101, 8'h00, 8'hA8};
        tbl[15] = '{1'b1, 1'b0, 3'b110, 8'h00, 8'h00};

        // Reset state and register access with the LCD off.
        do_reset();
        chk("rst_h", h, 0);
        chk("rst_v", v, 0);
        chk("rst_mode", mode, 0);
        chk("rst_int_stat", int_stat, 0);
        chk("rst_int_vbl", int_vbl, 0);
        chk("rst_line_start", line_start, 0);
        step();
        for (int i = 0; i < 16; i++) begin
            {ff45, ff44, ff41} = tbl[i].sel;
            if (tbl[i].wr) begin
                cpu_wr = 1'b1; tb_oe = 1'b1; tb_dat = tbl[i].dat;
            end
            if (tbl[i].rd) begin
                cpu_rd = 1'b1;
                #1;
                chk($sformatf("tbl_rd[%0d]", i), d, tbl[i].exp);
            end
            step();
            bus_idle();
        end
        chk("off_int_stat", int_stat, 0);
        chk("off_h", h, 0);

        // Line timing, render_done handling and a full frame plus wrap.
        do_reset();
        lcd_en = 1'b1;
        for (int t = 1; t <= 2150; t++) begin
            step();
            eh = t % DOTS; ln = t / DOTS; ev = ln % LNS;
            if (ev >= VBL)                 em = 1;
            else if (eh < OAM)             em = 2;
            else if (ln == 0 && eh > 52)   em = 0;
            else if (ln == 2 && eh > 30)   em = 0;
            else if (eh == DOTS - 1)       em = 0;
            else                           em = 3;
            chk("run_h", h, eh);
            chk("run_v", v, ev);
            chk($sformatf("run_mode t=%0d", t), mode, em);
            chk("run_int_vbl", int_vbl, (eh == 0 && ev == VBL) ? 1 : 0);
            chk("run_line_start", line_start, (eh == 0) ? 1 : 0);
            render_done = (ln == 0 && (eh == 52 || eh == 10)) || (ln == 2 && eh == 30);
        end
        render_done = 1'b0;

        // LYC=10 with the coincidence source only.
        do_reset();
        wr(3'b100, 8'd10);
        wr(3'b001, 8'h40);
        cpu_rd = 1'b1; ff41 = 1'b1;
        lcd_en = 1'b1;
        pc = 0; ph = -1; pv = -1;
        for (int t = 1; t <= 1200; t++) begin
            step();
            eh = t % DOTS; ev = t / DOTS;
            chk("lyc_coin_bit", d[2], ((ev == 10 && eh >= 1) || (ev == 11 && eh == 0)) ? 1 : 0);
            if (int_stat) begin
                pc++; ph = eh; pv = ev;
            end
        end
        chk("lyc_pulse_count", pc, 1);
        chk("lyc_pulse_v", pv, 10);
        chk("lyc_pulse_h", ph, 1);

        // Hblank source rising while coincidence already holds the line high.
        do_reset();
        wr(3'b100, 8'd5);
        wr(3'b001, 8'h48);
        lcd_en = 1'b1;
        c4 = 0; c5 = 0; ph = -1;
        for (int t = 1; t <= 700; t++) begin
            step();
            eh = t % DOTS; ev = t / DOTS;
            if (int_stat && ev == 4) c4++;
            if (int_stat && ev == 5) begin
                c5++; ph = eh;
            end
            render_done = (eh == 40);
        end
        render_done = 1'b0;
        chk("blk_line4_count", c4, 1);
        chk("blk_line5_count", c5, 1);
        chk("blk_line5_h", ph, 1);

        // Last-line LY quirk and the vblank-entry OAM source.
        do_reset();
        wr(3'b100, 8'd0);
        wr(3'b001, 8'h60);
        cpu_rd = 1'b1; ff44 = 1'b1;
        lcd_en = 1'b1;
        c16 = 0; c17 = 0; c19 = 0; ph = -1; pv = -1;
        for (int t = 1; t <= 2005; t++) begin
            step();
            eh = t % DOTS; ev = (t / DOTS) % LNS;
            chk($sformatf("ly_read t=%0d", t), d, (ev == LNS - 1 && eh >= 4) ? 0 : ev);
            if (int_stat && t < 2000) begin
                if (ev == 16) begin
                    c16++; pv = eh;
                end
                if (ev == 17 || ev == 18) c17++;
                if (ev == 19) begin
                    c19++; ph = eh;
                end
            end
        end
        chk("vbe_pulse_count", c16, 1);
        chk("vbe_pulse_h", pv, 0);
        chk("vbl_mid_pulses", c17, 0);
        chk("quirk_pulse_count", c19, 1);
        chk("quirk_pulse_h", ph, 5);

        // LCD dropped in mode 3, then re-enabled.
        do_reset();
        wr(3'b001, 8'h78);
        lcd_en = 1'b1;
        for (int t = 1; t <= 540; t++) step();
        chk("pre_drop_mode", mode, 3);
        chk("pre_drop_v", v, 5);
        lcd_en = 1'b0;
        cpu_rd = 1'b1; ff41 = 1'b1;
        #1;
        chk("drop_stat_read_comb", d, 8'hF8);
        step();
        chk("drop_h", h, 0);
        chk("drop_v", v, 0);
        chk("drop_mode", mode, 0);
        chk("drop_int_stat", int_stat, 0);
        chk("drop_stat_read", d, 8'hF8);
        lcd_en = 1'b1;
        step();
        chk("reen_h", h, 1);
        chk("reen_v", v, 0);
        chk("reen_mode", mode, 2);
        chk("reen_stat_read", d, 8'hFE);
        chk("reen_int_stat", int_stat, 1);

        // Reset wins over a simultaneous LYC write and clears the enables.
        bus_idle();
        reset_video = 1'b1;
        cpu_wr = 1'b1; ff45 = 1'b1; tb_oe = 1'b1; tb_dat = 8'h33;
        step();
        bus_idle();
        reset_video = 1'b0;
        cpu_rd = 1'b1; ff45 = 1'b1;
        #1;
        chk("rst_prio_lyc", d, 8'h00);
        ff45 = 1'b0; ff41 = 1'b1;
        #1;
        chk("rst_clears_en", d, 8'h80);
        bus_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
